// File: rtl/ddc_nco_mixer_iq_pkg.sv
// ddc_pkg: constants, the sample type and width helpers shared by the DDC
// mixer slice (mixer top and its sin/cos table).
package ddc_pkg;

  localparam int MIX_LATENCY         = 4;
  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_COEFF_WIDTH = 16;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

  // Width of a full-precision sum of two data*coeff products.
  function automatic int mix_sum_width(input int data_w, input int coeff_w);
    return data_w + coeff_w + 1;
  endfunction

  // Right shift that brings a product sum back to sample scale.
  function automatic int mix_shift(input int coeff_w);
    return coeff_w - 1;
  endfunction

  // Peak value stored in the sin/cos table.
  function automatic int coeff_amplitude(input int coeff_w);
    return (1 << (coeff_w - 1)) - 1;
  endfunction

  // Round to nearest, halves away from zero; used only at elaboration.
  function automatic int coeff_round(input real x);
    if (x >= 0.0) begin
      return $rtoi(x + 0.5);
    end
    return -$rtoi(-x + 0.5);
  endfunction

endpackage

// File: rtl/ddc_nco_mixer_iq_nco_sincos_lut.sv
// nco_sincos_lut: one-turn cos/sin ROM with a registered dual read.
// Contents are computed at elaboration; en stalls the read register with
// the rest of the mixer pipe.
module nco_sincos_lut import ddc_pkg::*; #(
  parameter int LUT_BITS    = 10,
  parameter int COEFF_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          en,
  input  logic [LUT_BITS-1:0]           addr,
  output logic signed [COEFF_WIDTH-1:0] cos_val,
  output logic signed [COEFF_WIDTH-1:0] sin_val
);

  localparam int  DEPTH  = 1 << LUT_BITS;
  localparam real TWO_PI = 6.283185307179586;
  localparam real AMP    = real'(coeff_amplitude(COEFF_WIDTH));

  logic signed [COEFF_WIDTH-1:0] cos_rom [DEPTH];
  logic signed [COEFF_WIDTH-1:0] sin_rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam real ANGLE = TWO_PI * real'(a) / real'(DEPTH);
    assign cos_rom[a] = COEFF_WIDTH'(coeff_round(AMP * $cos(ANGLE)));
    assign sin_rom[a] = COEFF_WIDTH'(coeff_round(AMP * $sin(ANGLE)));
  end

  // Registered table read, held while the pipe is stalled.
  always_ff @(posedge clk) begin
    if (en) begin
      cos_val <= cos_rom[addr];
      sin_val <= sin_rom[addr];
    end
  end

endmodule

// File: rtl/ddc_nco_mixer_iq.sv
// ddc_nco_mixer_iq: multiplies each accepted IQ beat by exp(-j*phi) from a
// phase-accumulator NCO. Four-stage pipe (register, table read, multiply,
// round/saturate) with whole-pipe stall on output backpressure.
// Optional build macro DDC_NCO_MIXER_PHASE_RESET_ON_TLAST_EN: when defined,
// the accumulator returns to 0 after each accepted tlast beat.
module ddc_nco_mixer_iq import ddc_pkg::*; #(
  parameter int DATA_WIDTH  = 16,
  parameter int PHASE_WIDTH = 24,
  parameter int LUT_BITS    = 10,
  parameter int COEFF_WIDTH = 16,
  parameter logic [PHASE_WIDTH-1:0] PHASE_INC_INIT = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [PHASE_WIDTH-1:0]       phase_inc_tdata,
  input  logic                         phase_inc_tvalid,
  input  logic                         in_tvalid,
  input  logic                         in_tlast,
  output logic                         in_tready,
  input  logic signed [DATA_WIDTH-1:0] in_itdata,
  input  logic signed [DATA_WIDTH-1:0] in_qtdata,
  output logic                         out_tvalid,
  output logic                         out_tlast,
  input  logic                         out_tready,
  output logic signed [DATA_WIDTH-1:0] out_itdata,
  output logic signed [DATA_WIDTH-1:0] out_qtdata
);

  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int SUM_W  = mix_sum_width(DATA_WIDTH, COEFF_WIDTH);
  localparam int SHIFT  = mix_shift(COEFF_WIDTH);

  localparam logic signed [SUM_W-1:0] ROUND_K =
    {{(SUM_W-COEFF_WIDTH+1){1'b0}}, 1'b1, {(COEFF_WIDTH-2){1'b0}}};
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic                          en;
  logic                          accept;
  logic [PHASE_WIDTH-1:0]        phase_inc_q;
  logic [PHASE_WIDTH-1:0]        acc;

  logic                          s1_valid, s2_valid, s3_valid;
  logic                          s1_last, s2_last, s3_last;
  logic signed [DATA_WIDTH-1:0]  s1_i, s1_q, s2_i, s2_q;
  logic [LUT_BITS-1:0]           s1_addr;
  logic signed [COEFF_WIDTH-1:0] cos_s2, sin_s2;
  logic signed [PROD_W-1:0]      p_ic, p_qs, p_qc, p_is;

  logic signed [SUM_W-1:0]       sum_i, sum_q, scl_i, scl_q;
  logic signed [DATA_WIDTH-1:0]  sat_i, sat_q;

  assign en        = ~out_tvalid | out_tready;
  assign in_tready = en & ~reset & ~clear;
  assign accept    = in_tvalid & in_tready;

  // Phase increment register; only a full reset restores the initial value.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_inc_q <= PHASE_INC_INIT;
    end else if (phase_inc_tvalid) begin
      phase_inc_q <= phase_inc_tdata;
    end
  end

  // Phase accumulator advances by the pre-update increment on each accept.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (accept) begin
`ifdef DDC_NCO_MIXER_PHASE_RESET_ON_TLAST_EN
      if (in_tlast) begin
        acc <= '0;
      end else begin
        acc <= acc + phase_inc_q;
      end
`else
      acc <= acc + phase_inc_q;
`endif
    end
  end

  // Valid and tlast shift register; a flush drops every in-flight beat.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      out_tvalid <= 1'b0;
      s1_last    <= 1'b0;
      s2_last    <= 1'b0;
      s3_last    <= 1'b0;
      out_tlast  <= 1'b0;
    end else if (en) begin
      s1_valid   <= accept;
      s2_valid   <= s1_valid;
      s3_valid   <= s2_valid;
      out_tvalid <= s3_valid;
      s1_last    <= in_tlast;
      s2_last    <= s1_last;
      s3_last    <= s2_last;
      out_tlast  <= s3_last;
    end
  end

  nco_sincos_lut #(
    .LUT_BITS    (LUT_BITS),
    .COEFF_WIDTH (COEFF_WIDTH)
  ) u_lut (
    .clk     (clk),
    .en      (en),
    .addr    (s1_addr),
    .cos_val (cos_s2),
    .sin_val (sin_s2)
  );

  // Data path stages 1-3; bubbles carry don't-care data alongside valid=0.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_i    <= in_itdata;
      s1_q    <= in_qtdata;
      s1_addr <= acc[PHASE_WIDTH-1 -: LUT_BITS];
      s2_i    <= s1_i;
      s2_q    <= s1_q;
      p_ic    <= PROD_W'(s2_i) * PROD_W'(cos_s2);
      p_qs    <= PROD_W'(s2_q) * PROD_W'(sin_s2);
      p_qc    <= PROD_W'(s2_q) * PROD_W'(cos_s2);
      p_is    <= PROD_W'(s2_i) * PROD_W'(sin_s2);
    end
  end

  // Full-precision sums, round-half-up scaling and saturation to sample range.
  always_comb begin
    sum_i = SUM_W'(p_ic) + SUM_W'(p_qs) + ROUND_K;
    sum_q = SUM_W'(p_qc) - SUM_W'(p_is) + ROUND_K;
    scl_i = sum_i >>> SHIFT;
    scl_q = sum_q >>> SHIFT;
    if (scl_i > SAT_MAX) begin
      sat_i = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scl_i < SAT_MIN) begin
      sat_i = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_i = scl_i[DATA_WIDTH-1:0];
    end
    if (scl_q > SAT_MAX) begin
      sat_q = SAT_MAX[DATA_WIDTH-1:0];
    end else if (scl_q < SAT_MIN) begin
      sat_q = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_q = scl_q[DATA_WIDTH-1:0];
    end
  end

  // Output register, held while a valid beat waits for out_tready.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      out_itdata <= '0;
      out_qtdata <= '0;
    end else if (en) begin
      out_itdata <= sat_i;
      out_qtdata <= sat_q;
    end
  end

endmodule

// File: tb/tb_ddc_nco_mixer_iq.sv
// tb_ddc_nco_mixer_iq: directed, table-driven bench for the NCO mixer with
// hand-computed expected IQ values and a few multi-cycle sequences.
module tb_ddc_nco_mixer_iq;

  localparam int DW = 16;
  localparam int PW = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 clear;
  logic [PW-1:0]        phase_inc_tdata;
  logic                 phase_inc_tvalid;
  logic                 in_tvalid;
  logic                 in_tlast;
  logic                 in_tready;
  logic signed [DW-1:0] in_itdata;
  logic signed [DW-1:0] in_qtdata;
  logic                 out_tvalid;
  logic                 out_tlast;
  logic                 out_tready = 1'b1;
  logic signed [DW-1:0] out_itdata;
  logic signed [DW-1:0] out_qtdata;

  int errors = 0;
  int checks = 0;
  int cycle_cnt = 0;
  int ready_mode = 0;
  int last_accept_cycle = 0;

  logic signed [DW-1:0] mon_i [$];
  logic signed [DW-1:0] mon_q [$];
  logic                 mon_l [$];
  int                   mon_cyc [$];
  logic [33:0]          stab_prev [$];
  logic [33:0]          stab_cur [$];
  logic [33:0]          prev_word = '0;
  logic                 prev_stall = 1'b0;

  typedef struct packed {
    logic [PW-1:0]        inc;
    logic [DW-1:0]        in_i;
    logic [DW-1:0]        in_q;
    logic [3:0][DW-1:0]   exp_i;
    logic [3:0][DW-1:0]   exp_q;
  } vec_t;

  vec_t vecs [6];

  ddc_nco_mixer_iq dut (
    .clk              (clk),
    .reset            (reset),
    .clear            (clear),
    .phase_inc_tdata  (phase_inc_tdata),
    .phase_inc_tvalid (phase_inc_tvalid),
    .in_tvalid        (in_tvalid),
    .in_tlast         (in_tlast),
    .in_tready        (in_tready),
    .in_itdata        (in_itdata),
    .in_qtdata        (in_qtdata),
    .out_tvalid       (out_tvalid),
    .out_tlast        (out_tlast),
    .out_tready       (out_tready),
    .out_itdata       (out_itdata),
    .out_qtdata       (out_qtdata)
  );

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Downstream ready: held high, or randomly toggled in stall mode.
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) out_tready = ($urandom_range(0, 99) < 60);
    else out_tready = 1'b1;
  end

  // Output monitor: records transferred beats and stalled-cycle snapshots.
  always @(negedge clk) begin
    if (!reset && !clear) begin
      if (prev_stall) begin
        stab_prev.push_back(prev_word);
        stab_cur.push_back({out_tvalid, out_tlast, out_itdata, out_qtdata});
      end
      if (out_tvalid && out_tready) begin
        mon_i.push_back(out_itdata);
        mon_q.push_back(out_qtdata);
        mon_l.push_back(out_tlast);
        mon_cyc.push_back(cycle_cnt);
      end
      prev_stall = out_tvalid && !out_tready;
      prev_word  = {out_tvalid, out_tlast, out_itdata, out_qtdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic vec_t mkVec(input int inc, input int ii, input int qq,
                                 input int e0i, input int e0q, input int e1i, input int e1q,
                                 input int e2i, input int e2q, input int e3i, input int e3q);
    vec_t v;
    v.inc      = PW'(inc);
    v.in_i     = DW'(ii);
    v.in_q     = DW'(qq);
    v.exp_i[0] = DW'(e0i);
    v.exp_q[0] = DW'(e0q);
    v.exp_i[1] = DW'(e1i);
    v.exp_q[1] = DW'(e1q);
    v.exp_i[2] = DW'(e2i);
    v.exp_q[2] = DW'(e2q);
    v.exp_i[3] = DW'(e3i);
    v.exp_q[3] = DW'(e3q);
    return v;
  endfunction

  function automatic longint rnd(input longint x);
    return (x * 32767 + 16384) >>> 15;
  endfunction

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int si, input int sq, input logic sl,
                               input logic ld, input logic [PW-1:0] inc);
    int guard;
    in_itdata        = DW'(si);
    in_qtdata        = DW'(sq);
    in_tlast         = sl;
    in_tvalid        = 1'b1;
    phase_inc_tvalid = ld;
    phase_inc_tdata  = inc;
    guard = 0;
    @(negedge clk);
    while (!in_tready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_tready got 0, expected 1");
    end else begin
      last_accept_cycle = cycle_cnt;
    end
    @(posedge clk);
    #1;
    in_tvalid        = 1'b0;
    in_tlast         = 1'b0;
    phase_inc_tvalid = 1'b0;
  endtask

  task automatic setInc(input logic [PW-1:0] inc);
    phase_inc_tvalid = 1'b1;
    phase_inc_tdata  = inc;
    @(posedge clk);
    #1;
    phase_inc_tvalid = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    @(negedge clk);
    checkOutput("clear_in_tready", in_tready, 0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    checkOutput("clear_out_tvalid", out_tvalid, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic waitOutputs(input int base, input int n);
    int guard;
    guard = 0;
    while (mon_i.size() < base + n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (mon_i.size() < base + n) begin
      checks++;
      errors++;
      $display("[TB] FAIL output_timeout: got %0d beats, expected %0d", mon_i.size() - base, n);
    end
    @(posedge clk);
    #1;
  endtask

  int base;
  int sbase;
  int acc_c;
  int exp_ti [6];
  int exp_tq [6];
  longint ei, eq, xi, xq;

  initial begin
    reset            = 1'b1;
    clear            = 1'b0;
    in_tvalid        = 1'b0;
    in_tlast         = 1'b0;
    in_itdata        = '0;
    in_qtdata        = '0;
    phase_inc_tvalid = 1'b0;
    phase_inc_tdata  = '0;

    vecs[0] = mkVec(0,        1000,   0,      1000, 0,      1000, 0,      1000, 0,      1000, 0);
    vecs[1] = mkVec(1 << 22,  1000,   0,      1000, 0,      0, -1000,     -1000, 0,     0, 1000);
    vecs[2] = mkVec(1 << 21,  32767,  32767,  32766, 32766, 32767, 0,     32766, -32766, 0, -32768);
    vecs[3] = mkVec(1 << 21,  -32768, -32768, -32767, -32767, -32768, 0,  -32767, 32767, 0, 32767);
    vecs[4] = mkVec(1 << 22,  0,      1000,   0, 1000,      1000, 0,      0, -1000,     -1000, 0);
    vecs[5] = mkVec(1 << 23,  -500,   300,    -500, 300,    500, -300,    -500, 300,    500, -300);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_tvalid", out_tvalid, 0);
    checkOutput("reset_out_tlast", out_tlast, 0);
    checkOutput("reset_out_i", out_itdata, 0);
    checkOutput("reset_out_q", out_qtdata, 0);
    checkOutput("reset_in_tready", in_tready, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_in_tready", in_tready, 1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      setInc(vecs[v].inc);
      doClear();
      base = mon_i.size();
      for (int k = 0; k < 4; k++) begin
        applyStimulus($signed(vecs[v].in_i), $signed(vecs[v].in_q), 1'b0, 1'b0, '0);
      end
      waitOutputs(base, 4);
      for (int k = 0; k < 4 && base + k < mon_i.size(); k++) begin
        checkOutput($sformatf("vec%0d_i%0d", v, k), mon_i[base+k], $signed(vecs[v].exp_i[k]));
        checkOutput($sformatf("vec%0d_q%0d", v, k), mon_q[base+k], $signed(vecs[v].exp_q[k]));
      end
    end

    setInc(0);
    doClear();
    base = mon_i.size();
    applyStimulus(1000, 0, 1'b1, 1'b0, '0);
    acc_c = last_accept_cycle;
    waitOutputs(base, 1);
    if (mon_i.size() > base) begin
      checkOutput("latency", mon_cyc[base] - acc_c, 4);
      checkOutput("latency_tlast", mon_l[base], 1);
      checkOutput("latency_i", mon_i[base], 1000);
    end

    setInc(1 << 22);
    doClear();
    ready_mode = 1;
    base  = mon_i.size();
    sbase = stab_cur.size();
    for (int k = 0; k < 100; k++) begin
      applyStimulus(k * 13 - 600, 450 - k * 9, (k % 10) == 9, 1'b0, '0);
    end
    waitOutputs(base, 100);
    ready_mode = 0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("stall_beat_count", mon_i.size() - base, 100);
    for (int k = 0; k < 100 && base + k < mon_i.size(); k++) begin
      xi = k * 13 - 600;
      xq = 450 - k * 9;
      case (k % 4)
        0: begin ei = rnd(xi);  eq = rnd(xq);  end
        1: begin ei = rnd(xq);  eq = rnd(-xi); end
        2: begin ei = rnd(-xi); eq = rnd(-xq); end
        default: begin ei = rnd(-xq); eq = rnd(xi); end
      endcase
      checkOutput($sformatf("stall_i%0d", k), mon_i[base+k], ei);
      checkOutput($sformatf("stall_q%0d", k), mon_q[base+k], eq);
      checkOutput($sformatf("stall_last%0d", k), mon_l[base+k], ((k % 10) == 9) ? 1 : 0);
    end
    checkOutput("stall_seen", (stab_cur.size() > sbase) ? 1 : 0, 1);
    for (int j = sbase; j < stab_cur.size(); j++) begin
      checkOutput($sformatf("stall_hold%0d", j - sbase), stab_cur[j], stab_prev[j]);
    end

    setInc(1 << 22);
    doClear();
    base = mon_i.size();
    applyStimulus(1000, 0, 1'b0, 1'b1, 24'(1 << 23));
    applyStimulus(1000, 0, 1'b0, 1'b0, '0);
    applyStimulus(1000, 0, 1'b0, 1'b0, '0);
    waitOutputs(base, 3);
    if (mon_i.size() >= base + 3) begin
      checkOutput("incupd_i0", mon_i[base],   1000);
      checkOutput("incupd_q0", mon_q[base],   0);
      checkOutput("incupd_i1", mon_i[base+1], 0);
      checkOutput("incupd_q1", mon_q[base+1], -1000);
      checkOutput("incupd_i2", mon_i[base+2], 0);
      checkOutput("incupd_q2", mon_q[base+2], 1000);
    end

    base = mon_i.size();
    applyStimulus(500, 0, 1'b0, 1'b0, '0);
    applyStimulus(500, 0, 1'b0, 1'b0, '0);
    doClear();
    applyStimulus(1000, 0, 1'b0, 1'b0, '0);
    applyStimulus(1000, 0, 1'b0, 1'b0, '0);
    applyStimulus(1000, 0, 1'b0, 1'b0, '0);
    waitOutputs(base, 3);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    checkOutput("clear_beat_count", mon_i.size() - base, 3);
    if (mon_i.size() >= base + 3) begin
      checkOutput("clear_i0", mon_i[base],   1000);
      checkOutput("clear_q0", mon_q[base],   0);
      checkOutput("clear_i1", mon_i[base+1], -1000);
      checkOutput("clear_q1", mon_q[base+1], 0);
      checkOutput("clear_i2", mon_i[base+2], 1000);
    end

`ifdef DDC_NCO_MIXER_PHASE_RESET_ON_TLAST_EN
    exp_ti = '{1000, 0, -1000, 1000, 0, -1000};
    exp_tq = '{0, -1000, 0, 0, -1000, 0};
`else
    exp_ti = '{1000, 0, -1000, 0, 1000, 0};
    exp_tq = '{0, -1000, 0, 1000, 0, -1000};
`endif
    setInc(1 << 22);
    doClear();
    base = mon_i.size();
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1000, 0, (k % 3) == 2, 1'b0, '0);
    end
    waitOutputs(base, 6);
    for (int k = 0; k < 6 && base + k < mon_i.size(); k++) begin
      checkOutput($sformatf("pkt_i%0d", k), mon_i[base+k], exp_ti[k]);
      checkOutput($sformatf("pkt_q%0d", k), mon_q[base+k], exp_tq[k]);
      checkOutput($sformatf("pkt_last%0d", k), mon_l[base+k], ((k % 3) == 2) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ddc_nco_mixer_iq.md
Name: ddc_nco_mixer_iq

Overview:
- Digital downconversion mixer that sits directly upstream of the CIC-decimate + FIR-LPF IQ chain.
- Multiplies each accepted complex input sample by exp(-j*phi), where phi comes from a phase-accumulator NCO, and emits baseband IQ.
- AXI-stream-style valid/ready on both sides. Fixed-latency pipeline with whole-pipe stall on backpressure.

Parameters:
- DATA_WIDTH, 16, width of the I and Q samples in and out (signed two's complement).
- PHASE_WIDTH, 24, phase accumulator and increment width (unsigned; full scale = one turn).
- LUT_BITS, 10, number of accumulator MSBs used to address the sin/cos table (2^LUT_BITS entries per turn; truncation, no dither).
- COEFF_WIDTH, 16, signed sin/cos table word width; amplitude = 2^(COEFF_WIDTH-1)-1.
- PHASE_INC_INIT, 0, phase increment value loaded on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- clear  in  1  synchronous flush; same effect as reset except that phase_inc is retained
- phase_inc_tdata  in  PHASE_WIDTH  new phase increment
- phase_inc_tvalid  in  1  loads phase_inc_tdata when high (always accepted)
- in_tvalid  in  1  input beat valid
- in_tlast  in  1  input beat last
- in_tready  out  1  input ready
- in_itdata  in  DATA_WIDTH  input I
- in_qtdata  in  DATA_WIDTH  input Q
- out_tvalid  out  1  output beat valid
- out_tlast  out  1  tlast of the corresponding input beat
- out_tready  in  1  downstream ready
- out_itdata  out  DATA_WIDTH  mixed I
- out_qtdata  out  DATA_WIDTH  mixed Q

Behaviour:
- Reset/clear values:
  - out_tvalid=0, out_tlast=0, out_itdata=0, out_qtdata=0.
  - Accumulator = 0; all pipeline valid bits = 0.
  - reset sets phase_inc to PHASE_INC_INIT; clear does not touch phase_inc.
- Handshake:
  - en = ~out_tvalid | out_tready.
  - in_tready = en & ~reset & ~clear.
  - All pipeline stages advance only when en=1; valid, data and tlast bubbles move with the pipe.
  - Once out_tvalid is high, outputs hold stable until out_tready.
- Latency: exactly 4 en-cycles from input accept to out_tvalid.
  - S1: register input, tlast and lut_addr = acc[PHASE_WIDTH-1 -: LUT_BITS].
  - S2: registered table read of cos and sin.
  - S3: four signed products.
  - S4: sum, round, saturate into the output register.
  - Throughput is one beat per cycle when out_tready is held high.
- NCO:
  - Accepted beat k is mixed with phase P_k.
  - P_{k+1} = P_k + phase_inc (mod 2^PHASE_WIDTH). The accumulator advances only on accept.
  - If phase_inc_tvalid and an accept happen in the same cycle, the add uses the old increment; the new increment applies from the next accept.
- Table:
  - cos[a] = round(A*cos(2*pi*a/2^LUT_BITS)), sin[a] = round(A*sin(...)), with A = 2^(COEFF_WIDTH-1)-1.
  - Contents are computed at elaboration.
- Arithmetic:
  - out_i = I*cos + Q*sin; out_q = Q*cos - I*sin.
  - Sums are full precision, DATA_WIDTH+COEFF_WIDTH+1 bits.
  - Scale by >> (COEFF_WIDTH-1) with round-half-up: add 2^(COEFF_WIDTH-2) before the shift.
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Mid-operation reset/clear:
  - In-flight beats are discarded; nothing partial is emitted.
  - in_tready is low during that cycle.

Optional Feature:
- Macro: DDC_NCO_MIXER_PHASE_RESET_ON_TLAST_EN.
- Defined: after accepting a beat with in_tlast=1, the accumulator loads 0, so every packet starts at phase 0. The tlast beat itself still uses its own P_k.
- Undefined: the accumulator runs continuously across packet boundaries; tlast only passes through the pipe.

Decomposition:
- Shared package ddc_pkg:
  - Pipeline latency constant MIX_LATENCY=4.
  - Rounding/saturation width helper functions.
  - Signed sample typedef sized by DATA_WIDTH defaults.
- One sub-module: nco_sincos_lut (registered dual-output cos/sin ROM, address in, one-cycle latency).

Test Plan:
- phase_inc=0, input (1000,0) with tready=1 -> (1000,0) on every beat; first out_tvalid exactly 4 cycles after the first accept.
- phase_inc=2^22 (quarter turn), constant input (1000,0) -> repeating outputs (1000,0), (0,-1000), (-1000,0), (0,1000).
- phase_inc=2^21 (45 deg), input (32767,32767) -> out_i saturates to 32767, out_q=0; input (-32768,-32768) -> out_i=-32768, out_q=0.
- Random out_tready toggling with a 100-beat stream -> output sequence identical to the tready=1 run; outputs stable while stalled; no drops or duplicates.
- phase_inc_tvalid asserted in the same cycle as an accept -> that accept adds the old increment; the next accept adds the new one. Assert clear mid-stream -> out_tvalid=0 next cycle, accumulator restarts at 0, phase_inc kept.
- With DDC_NCO_MIXER_PHASE_RESET_ON_TLAST_EN defined, quarter-turn increment, 3-beat packets, input (1000,0) -> each packet outputs (1000,0), (0,-1000), (-1000,0). Without the macro, the packets continue the 4-phase cycle.
